// File: rtl/lut_access_arb_if.sv
// Handshake bundle between the LUT arbiter, its two read requesters, the loader and the LUT macro.
// slave = arbiter side; master = requesters + loader + LUT side.
interface lut_access_arb_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  rd0_valid;
  logic [ADDR_WIDTH-1:0] rd0_addr;
  logic                  rd0_ready;
  logic                  rd1_valid;
  logic [ADDR_WIDTH-1:0] rd1_addr;
  logic                  rd1_ready;

  logic                  rsp0_valid;
  logic [31:0]           rsp0_data;
  logic                  rsp0_err;
  logic                  rsp1_valid;
  logic [31:0]           rsp1_data;
  logic                  rsp1_err;

  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  wr_ready;

  logic [ADDR_WIDTH-1:0] lut_address;
  logic [31:0]           lut_data;
  logic                  lut_rden;
  logic                  lut_wren;
  logic [31:0]           lut_q;

  modport slave (
    input  rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    input  wr_valid, wr_addr, wr_data,
    input  lut_q,
    output rd0_ready, rd1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err,
    output wr_ready,
    output lut_address, lut_data, lut_rden, lut_wren
  );

  modport master (
    output rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    output wr_valid, wr_addr, wr_data,
    output lut_q,
    input  rd0_ready, rd1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err,
    input  wr_ready,
    input  lut_address, lut_data, lut_rden, lut_wren
  );
endinterface

// File: rtl/lut_access_arb.sv
// Two-requester round-robin read arbiter in front of a single-port LUT with 2-cycle read latency.
// Define LUT_ARB_WRITE_PORT_EN to enable the priority write (load) path; otherwise the LUT is read-only.
module lut_access_arb #(
  parameter int DEPTH      = 3072,
  parameter int ADDR_WIDTH = 12
) (
  input logic             clock,
  input logic             reset,
  lut_access_arb_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  wr_go;
  logic                  rd_go;
  logic                  gnt_port;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  gnt_err;

  logic ptr_q, ptr_d;
  logic s1_valid_q, s1_port_q, s1_err_q;
  logic s2_valid_q, s2_port_q, s2_err_q;
  logic rsp_live;

`ifdef LUT_ARB_WRITE_PORT_EN
  assign wr_go           = bus.wr_valid & ~reset;
  assign bus.lut_data    = bus.wr_data;
  assign bus.lut_address = wr_go ? bus.wr_addr : gnt_addr;
`else
  logic unused_wr;
  assign unused_wr       = ^{bus.wr_valid, bus.wr_addr, bus.wr_data};
  assign wr_go           = 1'b0;
  assign bus.lut_data    = 32'd0;
  assign bus.lut_address = gnt_addr;
`endif

  // A write owns the LUT for the whole cycle; reads only arbitrate when it is free.
  always_comb begin
    rd_go    = 1'b0;
    gnt_port = 1'b0;
    if (!reset && !wr_go) begin
      if (bus.rd0_valid && bus.rd1_valid) begin
        rd_go    = 1'b1;
        gnt_port = ptr_q;
      end else if (bus.rd0_valid) begin
        rd_go    = 1'b1;
        gnt_port = 1'b0;
      end else if (bus.rd1_valid) begin
        rd_go    = 1'b1;
        gnt_port = 1'b1;
      end
    end
  end

  assign gnt_addr = gnt_port ? bus.rd1_addr : bus.rd0_addr;
  assign gnt_err  = ({1'b0, gnt_addr} >= DEPTH_W);
  assign ptr_d    = rd_go ? ~gnt_port : ptr_q;

  assign bus.rd0_ready = rd_go & ~gnt_port;
  assign bus.rd1_ready = rd_go & gnt_port;
  assign bus.wr_ready  = wr_go;
  assign bus.lut_wren  = wr_go;
  assign bus.lut_rden  = rd_go & ~gnt_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= rd_go;
      s2_valid_q <= s1_valid_q;
    end
    s1_port_q <= gnt_port;
    s1_err_q  <= gnt_err;
    s2_port_q <= s1_port_q;
    s2_err_q  <= s1_err_q;
  end

  // Stage 2 lines up with the LUT output register; reset also suppresses a response due this cycle.
  assign rsp_live = s2_valid_q & ~reset;

  assign bus.rsp0_valid = rsp_live & ~s2_port_q;
  assign bus.rsp1_valid = rsp_live & s2_port_q;
  assign bus.rsp0_err   = bus.rsp0_valid & s2_err_q;
  assign bus.rsp1_err   = bus.rsp1_valid & s2_err_q;
  assign bus.rsp0_data  = (bus.rsp0_valid && !s2_err_q) ? bus.lut_q : 32'd0;
  assign bus.rsp1_data  = (bus.rsp1_valid && !s2_err_q) ? bus.lut_q : 32'd0;

endmodule

// File: tb/tb_lut_access_arb.sv
// Bench for lut_access_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_lut_access_arb;
  localparam int DEPTH = 3072;
  localparam int AW    = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_access_arb_if #(.ADDR_WIDTH(AW)) bus ();

  lut_access_arb #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // LUT macro: address register then output register.
  logic [31:0] lut_mem [0:4095];
  logic [31:0] lut_stage;
  always @(posedge clk) begin
    if (bus.lut_rden) lut_stage <= lut_mem[bus.lut_address];
    bus.lut_q <= lut_stage;
    if (bus.lut_wren) lut_mem[bus.lut_address] <= bus.lut_data;
  end

  // Reference model: LUT contents as seen by the arbiter, RR pointer, outstanding responses.
  typedef struct {
    int          due;
    bit          port;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] shadow [0:4095];
  rsp_t        expq[$];
  int          ptr_m = 0;
  bit          last_r0 = 0, last_r1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  bit          e_r0, e_r1, e_wr, e_rden, e_wren, has_op, g;
  bit          ev0, ev1, ee0, ee1;
  logic [31:0] ed0, ed1, op_addr, a;
  rsp_t        r;

  always @(negedge clk) begin
    e_r0 = 0; e_r1 = 0; e_wr = 0; e_rden = 0; e_wren = 0; has_op = 0; op_addr = 0;
    ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0; ed0 = 0; ed1 = 0;
    if (rst) begin
      expq.delete();
      ptr_m = 0;
`ifdef LUT_ARB_WRITE_PORT_EN
    end else if (bus.wr_valid) begin
      e_wr = 1; e_wren = 1; has_op = 1; op_addr = 32'(bus.wr_addr);
      chk("lut_data", bus.lut_data, bus.wr_data);
      shadow[bus.wr_addr] = bus.wr_data;
`endif
    end else if (bus.rd0_valid || bus.rd1_valid) begin
      if (bus.rd0_valid && bus.rd1_valid) g = (ptr_m == 1);
      else g = bus.rd1_valid;
      ptr_m = g ? 0 : 1;
      a = g ? 32'(bus.rd1_addr) : 32'(bus.rd0_addr);
      if (g) e_r1 = 1; else e_r0 = 1;
      if (a < DEPTH) begin
        e_rden = 1; has_op = 1; op_addr = a;
        expq.push_back('{due: cyc + 2, port: g, err: 1'b0, data: shadow[a]});
      end else begin
        expq.push_back('{due: cyc + 2, port: g, err: 1'b1, data: 32'd0});
      end
    end
    if (!rst && expq.size() > 0 && expq[0].due == cyc) begin
      r = expq.pop_front();
      if (r.port) begin ev1 = 1; ee1 = r.err; ed1 = r.data; end
      else        begin ev0 = 1; ee0 = r.err; ed0 = r.data; end
    end
`ifndef LUT_ARB_WRITE_PORT_EN
    chk("lut_data_tied", bus.lut_data, 32'd0);
`endif
    chk("rd0_ready", bus.rd0_ready, e_r0);
    chk("rd1_ready", bus.rd1_ready, e_r1);
    chk("wr_ready", bus.wr_ready, e_wr);
    chk("lut_wren", bus.lut_wren, e_wren);
    chk("lut_rden", bus.lut_rden, e_rden);
    if (has_op) chk("lut_address", 32'(bus.lut_address), op_addr);
    chk("rsp0_valid", bus.rsp0_valid, ev0);
    chk("rsp0_err", bus.rsp0_err, ee0);
    chk("rsp0_data", bus.rsp0_data, ed0);
    chk("rsp1_valid", bus.rsp1_valid, ev1);
    chk("rsp1_err", bus.rsp1_err, ee1);
    chk("rsp1_data", bus.rsp1_data, ed1);
    last_r0 = e_r0;
    last_r1 = e_r1;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd0_valid = 0; bus.rd0_addr = '0;
    bus.rd1_valid = 0; bus.rd1_addr = '0;
    bus.wr_valid  = 0; bus.wr_addr  = '0; bus.wr_data = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int rr;
    rr = int'($urandom_range(0, 99));
    if (rr < 8)       return AW'($urandom_range(DEPTH, 4095));
    else if (rr < 14) return AW'($urandom_range(DEPTH - 2, DEPTH - 1));
    else              return AW'($urandom_range(0, 63));
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      lut_mem[i] = 32'hA500_0000 | i;
      shadow[i]  = 32'hA500_0000 | i;
    end
    rst = 1;
    idle_inputs();
    bus.rd0_valid = 1; bus.rd1_valid = 1; bus.wr_valid = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_rd0_ready", bus.rd0_ready, 0);
    chk("reset_rd1_ready", bus.rd1_ready, 0);
    chk("reset_lut_rden", bus.lut_rden, 0);
    chk("reset_lut_wren", bus.lut_wren, 0);
    chk("reset_rsp0_valid", bus.rsp0_valid, 0);
    tick();
    rst = 0;
    idle_inputs();
    tick();

    // single read of address 5
    bus.rd0_valid = 1; bus.rd0_addr = 12'd5;
    @(negedge clk);
    chk("t1_rd0_ready", bus.rd0_ready, 1);
    chk("t1_lut_address", 32'(bus.lut_address), 32'd5);
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    chk("t1_rsp0_valid", bus.rsp0_valid, 1);
    chk("t1_rsp0_data", bus.rsp0_data, 32'hA500_0005);
    tick();

    // both requesters continuously after a reset: 0,1,0,1
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      bus.rd0_valid = (k < 4); bus.rd0_addr = 12'd10;
      bus.rd1_valid = (k < 4); bus.rd1_addr = 12'd20;
      @(negedge clk);
      if (k < 4) begin
        chk("t2_rd0_ready", bus.rd0_ready, (k % 2 == 0));
        chk("t2_rd1_ready", bus.rd1_ready, (k % 2 == 1));
      end
      if (k >= 2) begin
        chk("t2_rsp0_valid", bus.rsp0_valid, (k % 2 == 0));
        chk("t2_rsp1_valid", bus.rsp1_valid, (k % 2 == 1));
        if (k % 2 == 0) chk("t2_rsp0_data", bus.rsp0_data, 32'hA500_000A);
        else            chk("t2_rsp1_data", bus.rsp1_data, 32'hA500_0014);
      end
      tick();
    end
    idle_inputs();
    tick();

`ifdef LUT_ARB_WRITE_PORT_EN
    // write wins, read stalls one cycle then sees the new word
    bus.wr_valid = 1; bus.wr_addr = 12'd7; bus.wr_data = 32'hDEAD_BEEF;
    bus.rd0_valid = 1; bus.rd0_addr = 12'd7;
    @(negedge clk);
    chk("t3_wr_ready", bus.wr_ready, 1);
    chk("t3_lut_wren", bus.lut_wren, 1);
    chk("t3_rd0_stall", bus.rd0_ready, 0);
    tick();
    bus.wr_valid = 0;
    @(negedge clk);
    chk("t3_rd0_ready", bus.rd0_ready, 1);
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    chk("t3_rsp0_data", bus.rsp0_data, 32'hDEAD_BEEF);
    tick();
`else
    // write request ignored, read proceeds
    bus.wr_valid = 1; bus.wr_addr = 12'd7; bus.wr_data = 32'hDEAD_BEEF;
    bus.rd0_valid = 1; bus.rd0_addr = 12'd7;
    @(negedge clk);
    chk("t6_wr_ready", bus.wr_ready, 0);
    chk("t6_lut_wren", bus.lut_wren, 0);
    chk("t6_rd0_ready", bus.rd0_ready, 1);
    tick();
    idle_inputs();
    bus.wr_valid = 1; bus.wr_addr = 12'd7; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    @(negedge clk);
    chk("t6_rsp0_data", bus.rsp0_data, 32'hA500_0007);
    idle_inputs();
    tick();
`endif

    // last in-range word, then first out-of-range word
    bus.rd0_valid = 1; bus.rd0_addr = 12'd3071;
    @(negedge clk);
    chk("t4_rden_3071", bus.lut_rden, 1);
    tick();
    idle_inputs();
    bus.rd1_valid = 1; bus.rd1_addr = 12'd3072;
    @(negedge clk);
    chk("t4_rd1_ready", bus.rd1_ready, 1);
    chk("t4_rden_3072", bus.lut_rden, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t4_rsp0_data", bus.rsp0_data, 32'hA500_0BFF);
    tick();
    @(negedge clk);
    chk("t4_rsp1_valid", bus.rsp1_valid, 1);
    chk("t4_rsp1_err", bus.rsp1_err, 1);
    chk("t4_rsp1_data", bus.rsp1_data, 32'd0);
    tick();

    // reset one cycle after a grant drops the read and clears the pointer
    bus.rd1_valid = 1; bus.rd1_addr = 12'd9;
    @(negedge clk);
    chk("t5_rd1_ready", bus.rd1_ready, 1);
    tick();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    bus.rd0_valid = 1; bus.rd0_addr = 12'd11;
    bus.rd1_valid = 1; bus.rd1_addr = 12'd12;
    @(negedge clk);
    chk("t5_no_rsp1", bus.rsp1_valid, 0);
    chk("t5_ptr0_grant", bus.rd0_ready, 1);
    tick();
    idle_inputs();
    tick();
    tick();

    // random traffic; requesters hold until granted
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!bus.rd0_valid || last_r0) begin
        bus.rd0_valid = ($urandom_range(0, 99) < 55);
        bus.rd0_addr  = rnd_addr();
      end
      if (!bus.rd1_valid || last_r1) begin
        bus.rd1_valid = ($urandom_range(0, 99) < 55);
        bus.rd1_addr  = rnd_addr();
      end
      bus.wr_valid = ($urandom_range(0, 99) < 15);
      bus.wr_addr  = AW'($urandom_range(0, 63));
      bus.wr_data  = $urandom();
      tick();
    end
    rst = 0;
    idle_inputs();
    repeat (4) tick();
    @(negedge clk);
    chk("drain_outstanding", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lut_access_arb.md
LUT_ACCESS_ARB -- requirements
Module: lut_access_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, number of LUT words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, LUT address width.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports rd0_valid / rd1_valid, input, 1 each, read request from requester 0 / 1.
REQ-006 SHALL have ports rd0_addr / rd1_addr, input, ADDR_WIDTH each, read address.
REQ-007 SHALL have ports rd0_ready / rd1_ready, output, 1 each, request accepted this cycle.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid, output, 1 each, response strobe.
REQ-009 SHALL have ports rsp0_data / rsp1_data, output, 32 each, response word.
REQ-010 SHALL have ports rsp0_err / rsp1_err, output, 1 each, address was >= DEPTH.
REQ-011 SHALL have ports wr_valid, wr_addr, wr_data, input, 1 / ADDR_WIDTH / 32, LUT load request.
REQ-012 SHALL have port wr_ready, output, 1, write accepted.
REQ-013 SHALL have ports lut_address, lut_data, lut_rden, lut_wren, output, ADDR_WIDTH / 32 / 1 / 1, drive to the single-port LUT.
REQ-014 SHALL have port lut_q, input, 32, LUT registered read data.

Function
REQ-015 SHALL issue at most one LUT operation per cycle; lut_* outputs are combinational from the grant and are sampled by the LUT on the same edge.
REQ-016 SHALL give a write priority over reads: wr_valid=1 -> wr_ready=1, lut_wren=1, lut_rden=0, both rd*_ready=0.
REQ-017 SHALL arbitrate reads round-robin with a 1-bit pointer (0 = requester 0 first); after a grant the pointer points to the non-granted requester; the pointer is unchanged on idle or write cycles.
REQ-018 SHALL assert rdN_ready only in the cycle the request is granted; rdN_valid/addr are held by the requester until ready.
REQ-019 SHALL, for an in-range granted read, assert lut_rden=1 with lut_address=rdN_addr.
REQ-020 SHALL, for a granted read with addr >= DEPTH, keep lut_rden=0 and mark the in-flight slot as an error.
REQ-021 SHALL track each read in a 2-stage pipeline {valid, port, err}, matching the LUT latency (address register plus output register).
REQ-022 SHALL pulse rspN_valid exactly 2 cycles after the rdN_ready cycle, with rspN_data=lut_q (or 0 and rspN_err=1 for errors).
REQ-023 SHALL hold rsp*_data and rsp*_err at 0 when rsp*_valid=0; responses have no backpressure.
REQ-024 SHALL sustain 1 read/cycle throughput; back-to-back grants alternate between requesters when both are valid.
REQ-025 SHALL return, for a read issued the cycle after a write to the same address, the newly written data.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, clear the pipeline valids, set the pointer to 0, and drive all rsp* outputs to 0 the following cycle.
REQ-027 SHALL force ready outputs and lut_rden/lut_wren to 0 while reset=1.
REQ-028 SHALL drop reads in flight at reset without producing a response.

Configuration
REQ-029 SHALL, with macro LUT_ARB_WRITE_PORT_EN defined, implement the write path per REQ-016.
REQ-030 SHALL, without LUT_ARB_WRITE_PORT_EN, tie lut_wren=0, lut_data=0 and wr_ready=0, ignore wr_* inputs, and leave the LUT read-only.

Verification
REQ-031 SHALL cover: rd0 addr=5 alone, cycle t -> rd0_ready at t, rsp0_valid at t+2, rsp0_data=LUT[5].
REQ-032 SHALL cover: rd0 and rd1 both valid continuously for 4 cycles after reset -> grants 0,1,0,1, with responses in the same order 2 cycles later.
REQ-033 SHALL cover: wr_valid with addr=7, data=0xDEADBEEF together with rd0 valid, then rd0 addr=7 -> write first, rd0 stalls 1 cycle, rsp0_data=0xDEADBEEF.
REQ-034 SHALL cover: rd1 addr=3072 -> lut_rden=0, rsp1_valid=1, rsp1_err=1, rsp1_data=0 two cycles later.
REQ-035 SHALL cover: reset asserted 1 cycle after a read grant -> no rsp pulse, pointer=0 after reset.
REQ-036 SHALL cover: without LUT_ARB_WRITE_PORT_EN, wr_valid=1 -> wr_ready=0, lut_wren=0, reads unaffected.
